word_byte_serializer: RTL and testbench
=======================================

# word_byte_serializer

Host-side transmitter for the core's byte-serial input link. It accepts 32-bit words (instructions or load data) into a small FIFO and streams each word out LSB-first, one byte per clock, on the 8-bit bus that drives the core's `data_in`. A `hold` input pauses the stream while the core is busy. This block is the sending end of the byte link the core receives on, and it replaces hand-timed byte stimulus in wrappers and benches.

## Interface

Parameters:
- `DEPTH`, 4: FIFO depth in words; power of two, ≥2.
- `IDLE_BYTE`, 8'h00: value driven on `data_out` while no word is being sent.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `wr_word`  in  32  word to enqueue.
- `wr_valid`  in  1  enqueue request.
- `wr_ready`  out  1  `!full`, combinational from the FIFO count.
- `hold`  in  1  stall from the consumer; while high, no new byte is presented.
- `data_out`  out  8  byte to the core's `data_in`; registered.
- `byte_valid`  out  1  high for exactly one cycle per newly presented byte; registered.
- `byte_index`  out  2  index of the byte on `data_out` (0 = LSB); registered.
- `word_done`  out  1  high in the same cycle as `byte_valid` for byte 3; registered.
- `fifo_level`  out  $clog2(DEPTH)+1  number of words queued, excluding the word being sent.

## Operation

- FIFO:
  - Push on an edge with `wr_valid && wr_ready`.
  - Pop happens only when the FSM loads a word.
  - Simultaneous push and pop: level is unchanged.
  - Push while full: ignored; `wr_ready` is low, so no handshake occurs.
  - No bypass path. A word pushed at edge k cannot be popped before edge k+1.
  - Read and write pointers wrap modulo `DEPTH`.
- FSM states:
  - IDLE:
    - `byte_valid`=0, `word_done`=0, `data_out`=`IDLE_BYTE`, `byte_index`=0.
    - If `!hold` and the FIFO is non-empty: pop into the 32-bit shift register and present byte 0 (`data_out`=word[7:0], `byte_valid`=1, `byte_index`=0). Go to SEND.
  - SEND, `hold`=1:
    - `byte_valid`<=0, `word_done`<=0.
    - `data_out` and `byte_index` keep their values; no byte is skipped or repeated.
  - SEND, `hold`=0, `byte_index`<3: present the next byte (`byte_index`+1, `data_out`=word[8i+7:8i]), `byte_valid`=1. `word_done`=1 when the new index is 3.
  - SEND, `hold`=0, `byte_index`=3 (word finished):
    - If the FIFO is non-empty: load the next word and present its byte 0 (back-to-back, 4 cycles per word sustained). Stay in SEND.
    - If the FIFO is empty: go to IDLE, driving the IDLE outputs.
- `hold` is sampled on every edge and takes priority over loading a word or advancing a byte.
- Reset (including mid-word): FIFO emptied, pointers cleared, shift register discarded, state IDLE.
- Reset values: `data_out`=`IDLE_BYTE`, `byte_valid`=0, `byte_index`=0, `word_done`=0, `fifo_level`=0, `wr_ready`=1.

## Timing

- Push accepted at edge k with the FIFO empty and the FSM in IDLE, `hold` low: byte 0 is visible after edge k+1, and byte i after edge k+1+i. `word_done` is visible after edge k+4.
- One cycle latency from the accepting edge to the first byte. Throughput is one byte per cycle while `hold`=0.
- Each `hold`-high edge during SEND adds exactly one cycle to the word.
- `wr_ready` reacts in the same cycle to level changes made at the previous edge.

## Test plan

- Reset, push 0xDEADBEEF, `hold`=0 → `data_out` EF, BE, AD, DE on 4 consecutive cycles with `byte_valid`=1 and `byte_index` 0..3. `word_done` is high only with DE. Then `data_out`=0x00, `byte_valid`=0.
- Push 0x8D080004 and then 0xCAFEF00D on consecutive edges → 04,00,08,8D,0D,F0,FE,CA with no gap. `fifo_level` goes 1→1→0 (first word popped, second pushed, then second popped).
- Push 0xDEADBEEF, raise `hold` for 3 cycles after byte BE → `data_out` stays BE with `byte_valid`=0 for 3 cycles. On release, AD and then DE follow. The word takes 7 cycles total.
- Hold high, push 5 words with `DEPTH`=4 → `wr_ready` drops after the 4th push, the 5th push is ignored, and `fifo_level`=4. Release `hold` → exactly 4 words (16 bytes) are sent in order.
- Reset asserted during byte 2 of 0x11223344 with a second word queued → the next cycle shows `data_out`=0x00, `byte_valid`=0, `fifo_level`=0, and no further bytes appear.
- Push while `hold`=1 in IDLE → no output until `hold` falls. Byte 0 appears one edge after `hold` is sampled low.

Source files
------------

// File: rtl/word_byte_serializer.sv
// Word-to-byte serializer: queues 32-bit words in a small FIFO and streams each
// one LSB-first, one byte per clock, pausing whenever the consumer raises hold.
module word_byte_serializer #(
   parameter int          DEPTH     = 4,
   parameter logic [7:0]  IDLE_BYTE = 8'h00
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [31:0]              wr_word,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic                     hold,
   output logic [7:0]               data_out,
   output logic                     byte_valid,
   output logic [1:0]               byte_index,
   output logic                     word_done,
   output logic [$clog2(DEPTH):0]   fifo_level
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic {
      ST_IDLE,
      ST_SEND
   } state_t;

   logic [31:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;

   state_t        r_state;
   logic [31:0]   r_shift;
   logic [7:0]    r_data_out;
   logic          r_byte_valid;
   logic [1:0]    r_byte_index;
   logic          r_word_done;

   state_t        w_state_nxt;
   logic [31:0]   w_shift_nxt;
   logic [7:0]    w_data_nxt;
   logic          w_valid_nxt;
   logic [1:0]    w_index_nxt;
   logic          w_done_nxt;
   logic          w_push;
   logic          w_pop;
   logic          w_empty;
   logic [31:0]   w_head;

   assign wr_ready   = (r_count != (AW+1)'(DEPTH));
   assign w_push     = wr_valid && wr_ready;
   assign w_empty    = (r_count == '0);
   assign w_head     = r_mem[r_rd_ptr];
   assign fifo_level = r_count;

   // NOTE: storage array carries no reset; the cleared pointers and count make stale entries unreachable.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wr_word;
      end
   end

   // Pop only sees words counted before this edge, so a fresh push is never bypassed.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: every signal gets a default first so no path through the case infers a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_data_nxt  = r_data_out;
      w_index_nxt = r_byte_index;
      w_valid_nxt = 1'b0;
      w_done_nxt  = 1'b0;
      w_pop       = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_data_nxt  = IDLE_BYTE;
            w_index_nxt = 2'd0;
            if (!hold && !w_empty) begin
               w_pop       = 1'b1;
               w_shift_nxt = w_head >> 8;
               w_data_nxt  = w_head[7:0];
               w_valid_nxt = 1'b1;
               w_state_nxt = ST_SEND;
            end
         end
         ST_SEND: begin
            if (!hold) begin
               if (r_byte_index != 2'd3) begin
                  w_shift_nxt = r_shift >> 8;
                  w_data_nxt  = r_shift[7:0];
                  w_index_nxt = r_byte_index + 2'd1;
                  w_valid_nxt = 1'b1;
                  w_done_nxt  = (r_byte_index == 2'd2);
               end else if (!w_empty) begin
                  w_pop       = 1'b1;
                  w_shift_nxt = w_head >> 8;
                  w_data_nxt  = w_head[7:0];
                  w_index_nxt = 2'd0;
                  w_valid_nxt = 1'b1;
               end else begin
                  w_data_nxt  = IDLE_BYTE;
                  w_index_nxt = 2'd0;
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_shift      <= '0;
         r_data_out   <= IDLE_BYTE;
         r_byte_valid <= 1'b0;
         r_byte_index <= 2'd0;
         r_word_done  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_shift      <= w_shift_nxt;
         r_data_out   <= w_data_nxt;
         r_byte_valid <= w_valid_nxt;
         r_byte_index <= w_index_nxt;
         r_word_done  <= w_done_nxt;
      end
   end

   assign data_out   = r_data_out;
   assign byte_valid = r_byte_valid;
   assign byte_index = r_byte_index;
   assign word_done  = r_word_done;

endmodule

// File: tb/tb_word_byte_serializer.sv
// Bench for word_byte_serializer: a word-level queue model predicts each edge's
// byte, and a negedge monitor matches presented bytes against a scoreboard.
module tb_word_byte_serializer;

   localparam int         DEPTH     = 4;
   localparam logic [7:0] IDLE_BYTE = 8'h00;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [31:0]             wr_word;
   logic                    wr_valid;
   logic                    wr_ready;
   logic                    hold;
   logic [7:0]              data_out;
   logic                    byte_valid;
   logic [1:0]              byte_index;
   logic                    word_done;
   logic [$clog2(DEPTH):0]  fifo_level;

   word_byte_serializer #(.DEPTH(DEPTH), .IDLE_BYTE(IDLE_BYTE)) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_word    (wr_word),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .hold       (hold),
      .data_out   (data_out),
      .byte_valid (byte_valid),
      .byte_index (byte_index),
      .word_done  (word_done),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] data;
      logic [1:0] idx;
      logic       done;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   bit          started  = 1'b0;

   // Reference model: queued words, the word in flight and how many of its bytes remain.
   logic [31:0] m_q[$];
   logic [31:0] m_cur;
   int          m_left;
   logic [7:0]  m_data;
   logic [1:0]  m_idx;
   logic        m_valid;
   logic        m_done;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (started && byte_valid === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_byte: got %h idx %0d with no byte expected at %0t",
                     data_out, byte_index, $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_data", {24'h0, data_out}, {24'h0, e.data});
            check("sb_index", {30'h0, byte_index}, {30'h0, e.idx});
            check("sb_word_done", {31'h0, word_done}, {31'h0, e.done});
         end
      end
   end

   // One clock edge: drive inputs, predict the edge, then compare just after it.
   task automatic step(input bit r, input bit h, input bit v, input logic [31:0] w);
      bit   emit;
      bit   push_ok;
      exp_t e;
      rst      = r;
      hold     = h;
      wr_valid = v;
      wr_word  = w;
      check("wr_ready", {31'h0, wr_ready}, {31'h0, (m_q.size() < DEPTH)});
      emit = 1'b0;
      if (r) begin
         m_q.delete();
         m_left = 0;
         m_data = IDLE_BYTE;
         m_idx  = 2'd0;
      end else begin
         push_ok = v && (m_q.size() < DEPTH);
         if (!h) begin
            if (m_left > 0) begin
               m_idx  = 2'(4 - m_left);
               m_left = m_left - 1;
               emit   = 1'b1;
            end else if (m_q.size() > 0) begin
               m_cur  = m_q.pop_front();
               m_idx  = 2'd0;
               m_left = 3;
               emit   = 1'b1;
            end else begin
               m_data = IDLE_BYTE;
               m_idx  = 2'd0;
            end
            if (emit) m_data = m_cur[8*m_idx +: 8];
         end
         if (push_ok) m_q.push_back(w);
      end
      m_valid = emit;
      m_done  = emit && (m_idx == 2'd3);
      @(posedge clk);
      #1;
      if (emit) begin
         e.data = m_data;
         e.idx  = m_idx;
         e.done = m_done;
         sb.push_back(e);
      end
      check("byte_valid", {31'h0, byte_valid}, {31'h0, m_valid});
      check("word_done", {31'h0, word_done}, {31'h0, m_done});
      check("data_out", {24'h0, data_out}, {24'h0, m_data});
      check("byte_index", {30'h0, byte_index}, {30'h0, m_idx});
      check("fifo_level", 32'(fifo_level), 32'(m_q.size()));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   initial begin
      rst      = 1'b1;
      hold     = 1'b0;
      wr_valid = 1'b0;
      wr_word  = '0;
      m_left   = 0;
      m_cur    = '0;
      m_data   = IDLE_BYTE;
      m_idx    = 2'd0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_data_out", {24'h0, data_out}, {24'h0, IDLE_BYTE});
      check("reset_byte_valid", {31'h0, byte_valid}, 32'h0);
      check("reset_byte_index", {30'h0, byte_index}, 32'h0);
      check("reset_word_done", {31'h0, word_done}, 32'h0);
      check("reset_fifo_level", 32'(fifo_level), 32'h0);
      check("reset_wr_ready", {31'h0, wr_ready}, 32'h1);
      started = 1'b1;
      rst = 1'b0;

      // Single word, no stall.
      step(1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
      idle(6);

      // Two words on consecutive edges stream without a gap.
      step(1'b0, 1'b0, 1'b1, 32'h8D080004);
      step(1'b0, 1'b0, 1'b1, 32'hCAFEF00D);
      idle(10);

      // Three hold cycles after byte BE.
      step(1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
      idle(2);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
      idle(4);

      // Fill past capacity while held, then release.
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 32'h01020304 * (i + 1));
      idle(20);

      // Reset during byte 2 with a second word queued.
      step(1'b0, 1'b0, 1'b1, 32'h11223344);
      step(1'b0, 1'b0, 1'b1, 32'h55667788);
      idle(2);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      idle(4);

      // Push while held in IDLE.
      step(1'b0, 1'b1, 1'b1, 32'hA5A55A5A);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
      idle(6);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom % 200) == 0, ($urandom % 4) == 0, ($urandom % 2) == 1, $urandom);
      end

      for (int i = 0; i < 40 && (m_q.size() > 0 || m_left > 0); i++) idle(1);
      idle(2);
      check("sb_drained", 32'(sb.size()), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
